// File: rtl/store_buffer.sv
// In-order store buffer between MEM and a byte-addressed doubleword memory.
// Loads forward from the youngest exact match, read memory on a clean miss, and stall on partial overlap.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  input  logic [63:0]              st_addr,
  input  logic [63:0]              st_data,
  output logic                     st_ready,
  input  logic                     ld_valid,
  input  logic [63:0]              ld_addr,
  output logic [63:0]              ld_data,
  output logic                     ld_hit,
  output logic                     ld_stall,
  output logic [63:0]              mem_addr,
  output logic [63:0]              mem_wdata,
  output logic                     mem_write,
  output logic                     mem_read,
  input  logic [63:0]              mem_rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [63:0]   addr_q [DEPTH];
  logic [63:0]   addr_d [DEPTH];
  logic [63:0]   data_q [DEPTH];
  logic [63:0]   data_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty_q, empty_d;
  logic          ready_q, ready_d;

  logic [PW-1:0] slot_s [DEPTH];
  logic          hit_s;
  logic          stall_s;
  logic [63:0]   fwd_data_s;
  logic          push_s;
  logic          pop_s;

  // Physical slot of the k-th oldest entry.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      slot_s[k] = head_q + PW'(k);
    end
  end

  // Oldest-to-youngest scan: an exact match clears any older conflict, a younger partial overlap re-raises it.
  always_comb begin
    hit_s      = 1'b0;
    stall_s    = 1'b0;
    fwd_data_s = 64'd0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < count_q) && (addr_q[slot_s[k]] == ld_addr)) begin
        hit_s      = 1'b1;
        stall_s    = 1'b0;
        fwd_data_s = data_q[slot_s[k]];
      end else if ((CW'(k) < count_q) &&
                   ({1'b0, addr_q[slot_s[k]]} <= ({1'b0, ld_addr} + 65'd7)) &&
                   ({1'b0, ld_addr} <= ({1'b0, addr_q[slot_s[k]]} + 65'd7))) begin
        stall_s = 1'b1;
      end else begin
        stall_s = stall_s;
      end
    end
  end

  // Memory port arbitration: a missing load owns the port, otherwise the head drains.
  always_comb begin
    ld_data   = 64'd0;
    ld_hit    = 1'b0;
    ld_stall  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = 64'd0;
    mem_wdata = 64'd0;
    if (reset) begin
      mem_write = 1'b0;
    end else begin
      if (ld_valid && stall_s) begin
        ld_stall = 1'b1;
      end else if (ld_valid && hit_s) begin
        ld_hit  = 1'b1;
        ld_data = fwd_data_s;
      end else if (ld_valid) begin
        mem_read = 1'b1;
        mem_addr = ld_addr;
        ld_data  = mem_rdata;
      end else begin
        ld_data = 64'd0;
      end
      if (!mem_read && (count_q != CW'(0))) begin
        mem_write = 1'b1;
        mem_addr  = addr_q[head_q];
        mem_wdata = data_q[head_q];
      end else begin
        mem_write = 1'b0;
      end
    end
  end

  // FIFO next state.
  always_comb begin
    push_s = st_valid && ready_q;
    pop_s  = mem_write;
    addr_d = addr_q;
    data_d = data_q;
    if (push_s) begin
      addr_d[tail_q] = st_addr;
      data_d[tail_q] = st_data;
    end else begin
      addr_d[tail_q] = addr_q[tail_q];
    end
    tail_d  = push_s ? (tail_q + PW'(1)) : tail_q;
    head_d  = pop_s  ? (head_q + PW'(1)) : head_q;
    count_d = count_q + CW'(push_s) - CW'(pop_s);
    ready_d = (count_d < CW'(DEPTH));
    empty_d = (count_d == CW'(0));
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        addr_q[k] <= 64'd0;
        data_q[k] <= 64'd0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      ready_q <= 1'b1;
    end else begin
      addr_q  <= addr_d;
      data_q  <= data_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      empty_q <= empty_d;
      ready_q <= ready_d;
    end
  end

  assign count    = count_q;
  assign empty    = empty_q;
  assign st_ready = ready_q;

endmodule

// File: tb/tb_store_buffer.sv
// Directed plus randomized bench for store_buffer with a queue-based reference model and byte memory.
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int MEMSZ = 512;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [63:0] st_addr;
  logic [63:0] st_data;
  logic        st_ready;
  logic        ld_valid;
  logic [63:0] ld_addr;
  logic [63:0] ld_data;
  logic        ld_hit;
  logic        ld_stall;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [63:0] mem_rdata;
  logic [2:0]  count;
  logic        empty;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] d;
  } ent_t;

  ent_t       q[$];
  logic [7:0] ref_mem [MEMSZ];
  logic [7:0] mem_b   [MEMSZ];

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_hit(ld_hit), .ld_stall(ld_stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_rdata(mem_rdata),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  // Data memory: combinational little-endian read, write at the clock edge.
  always_comb begin
    mem_rdata = 64'd0;
    for (int i = 0; i < 8; i++) begin
      mem_rdata[8*i +: 8] = mem_b[9'(mem_addr + 64'(i))];
    end
  end

  always @(posedge clk) begin
    if (mem_write) begin
      for (int i = 0; i < 8; i++) begin
        mem_b[9'(mem_addr + 64'(i))] <= mem_wdata[8*i +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_rd(input logic [63:0] a);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = ref_mem[9'(a + 64'(i))];
    return r;
  endfunction

  function automatic logic [63:0] tb_rd(input logic [63:0] a);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = mem_b[9'(a + 64'(i))];
    return r;
  endfunction

  function automatic bit overlaps(input logic [63:0] a, input logic [63:0] b);
    return ({1'b0, a} <= {1'b0, b} + 65'd7) && ({1'b0, b} <= {1'b0, a} + 65'd7);
  endfunction

  task automatic setin(input logic sv, input logic [63:0] sa, input logic [63:0] sd,
                       input logic lv, input logic [63:0] la);
    st_valid = sv;
    st_addr  = sa;
    st_data  = sd;
    ld_valid = lv;
    ld_addr  = la;
  endtask

  // One clock cycle: drive, predict from the model, compare, advance model at the edge.
  task automatic cyc(input logic sv, input logic [63:0] sa, input logic [63:0] sd,
                     input logic lv, input logic [63:0] la);
    int   j;
    bit   e_stall, e_hit, e_read, e_write, accept;
    logic [63:0] e_data, e_addr, e_wdata;
    ent_t e;
    setin(sv, sa, sd, lv, la);
    #2;
    e_stall = 0; e_hit = 0; e_read = 0; e_write = 0;
    e_data = 64'd0; e_addr = 64'd0; e_wdata = 64'd0;
    if (lv) begin
      j = -1;
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (j < 0 && q[i].a == la) j = i;
      end
      for (int i = j + 1; i < q.size(); i++) begin
        if (q[i].a != la && overlaps(q[i].a, la)) e_stall = 1;
      end
      if (e_stall) begin
        e_hit = 0;
      end else if (j >= 0) begin
        e_hit  = 1;
        e_data = q[j].d;
      end else begin
        e_read = 1;
        e_addr = la;
        e_data = ref_rd(la);
      end
    end
    if (!e_read && q.size() > 0) begin
      e_write = 1;
      e_addr  = q[0].a;
      e_wdata = q[0].d;
    end
    chk("ld_hit", 64'(ld_hit), 64'(e_hit));
    chk("ld_stall", 64'(ld_stall), 64'(e_stall));
    chk("mem_read", 64'(mem_read), 64'(e_read));
    chk("mem_write", 64'(mem_write), 64'(e_write));
    chk("count", 64'(count), 64'(q.size()));
    chk("empty", 64'(empty), 64'(q.size() == 0));
    chk("st_ready", 64'(st_ready), 64'(q.size() < DEPTH));
    if (!e_stall) chk("ld_data", ld_data, e_data);
    if (e_read || e_write) chk("mem_addr", mem_addr, e_addr);
    if (e_write) chk("mem_wdata", mem_wdata, e_wdata);
    accept = sv && (q.size() < DEPTH);
    @(posedge clk);
    #1;
    if (e_write) begin
      for (int i = 0; i < 8; i++) ref_mem[9'(e_addr + 64'(i))] = e_wdata[8*i +: 8];
      void'(q.pop_front());
    end
    if (accept) begin
      e.a = sa;
      e.d = sd;
      q.push_back(e);
    end
  endtask

  initial begin
    for (int i = 0; i < MEMSZ; i++) begin
      mem_b[i]   <= 8'h00;
      ref_mem[i] = 8'h00;
    end
    mem_b[0]   <= 8'hAC;
    ref_mem[0] = 8'hAC;
    reset = 1'b1;
    setin(1'b0, 64'd0, 64'd0, 1'b0, 64'd0);
    #3;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_st_ready", 64'(st_ready), 64'd1);
    chk("rst_mem_write", 64'(mem_write), 64'd0);
    chk("rst_mem_read", 64'(mem_read), 64'd0);
    chk("rst_ld_data", ld_data, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Idle load from address 0.
    setin(1'b0, 64'd0, 64'd0, 1'b1, 64'd0);
    #1;
    chk("idle_ld_read", 64'(mem_read), 64'd1);
    chk("idle_ld_data", ld_data, 64'hAC);
    chk("idle_ld_hit", 64'(ld_hit), 64'd0);
    cyc(1'b0, 64'd0, 64'd0, 1'b1, 64'd0);

    // Single store then drain and read back.
    cyc(1'b1, 64'd8, 64'h1122334455667788, 1'b0, 64'd0);
    setin(1'b0, 64'd0, 64'd0, 1'b0, 64'd0);
    #1;
    chk("single_wr", 64'(mem_write), 64'd1);
    chk("single_addr", mem_addr, 64'd8);
    cyc(1'b0, 64'd0, 64'd0, 1'b0, 64'd0);
    setin(1'b0, 64'd0, 64'd0, 1'b1, 64'd8);
    #1;
    chk("single_empty", 64'(empty), 64'd1);
    chk("single_rdback", ld_data, 64'h1122334455667788);
    cyc(1'b0, 64'd0, 64'd0, 1'b1, 64'd8);

    // Fill while a memory-reading load holds the port.
    for (int i = 0; i < 4; i++) cyc(1'b1, 64'(8 * i), 64'hA0 + 64'(i), 1'b1, 64'd40);
    setin(1'b1, 64'd32, 64'hFF, 1'b1, 64'd40);
    #1;
    chk("full_ready", 64'(st_ready), 64'd0);
    chk("full_nowr", 64'(mem_write), 64'd0);
    cyc(1'b1, 64'd32, 64'hFF, 1'b1, 64'd40);
    setin(1'b0, 64'd0, 64'd0, 1'b0, 64'd0);
    #1;
    chk("full_count", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      setin(1'b0, 64'd0, 64'd0, 1'b0, 64'd0);
      #1;
      chk("drain_wr", 64'(mem_write), 64'd1);
      chk("drain_addr", mem_addr, 64'(8 * i));
      cyc(1'b0, 64'd0, 64'd0, 1'b0, 64'd0);
    end

    // Youngest exact match forwards.
    cyc(1'b1, 64'd16, 64'd1, 1'b1, 64'd40);
    cyc(1'b1, 64'd16, 64'd2, 1'b1, 64'd40);
    setin(1'b0, 64'd0, 64'd0, 1'b1, 64'd16);
    #1;
    chk("fwd_hit", 64'(ld_hit), 64'd1);
    chk("fwd_data", ld_data, 64'd2);
    chk("fwd_noread", 64'(mem_read), 64'd0);
    cyc(1'b0, 64'd0, 64'd0, 1'b1, 64'd16);
    cyc(1'b0, 64'd0, 64'd0, 1'b0, 64'd0);

    // Partial overlap stalls until the store drains.
    cyc(1'b1, 64'd16, 64'h0807060504030201, 1'b1, 64'd40);
    setin(1'b0, 64'd0, 64'd0, 1'b1, 64'd20);
    #1;
    chk("ovl_stall", 64'(ld_stall), 64'd1);
    cyc(1'b0, 64'd0, 64'd0, 1'b1, 64'd20);
    setin(1'b0, 64'd0, 64'd0, 1'b1, 64'd20);
    #1;
    chk("ovl_release", 64'(ld_stall), 64'd0);
    chk("ovl_data", ld_data, ref_rd(64'd20));
    cyc(1'b0, 64'd0, 64'd0, 1'b1, 64'd20);

    // Asynchronous reset during a drain.
    for (int i = 0; i < 3; i++) cyc(1'b1, 64'd100 + 64'(8 * i), 64'hDEAD0 + 64'(i), 1'b1, 64'd200);
    setin(1'b0, 64'd0, 64'd0, 1'b0, 64'd0);
    #1;
    chk("arst_pre_wr", 64'(mem_write), 64'd1);
    reset = 1'b1;
    #1;
    chk("arst_wr", 64'(mem_write), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_empty", 64'(empty), 64'd1);
    q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) chk("arst_mem", tb_rd(64'd100 + 64'(8 * i)), ref_rd(64'd100 + 64'(8 * i)));

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic        sv, lv;
      logic [63:0] sa, sd, la;
      sv = 1'($urandom_range(0, 1));
      lv = ($urandom_range(0, 2) != 0);
      sa = ($urandom_range(0, 3) == 0) ? 64'(4 * $urandom_range(0, 15)) : 64'(8 * $urandom_range(0, 7));
      sd = {$urandom, $urandom};
      la = ($urandom_range(0, 4) == 0) ? 64'd200 : 64'(4 * $urandom_range(0, 15));
      cyc(sv, sa, sd, lv, la);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
